wb_data_mem: RTL and testbench
==============================

# wb_data_mem

Wishbone B4 pipelined-mode slave data memory, the responder end of the core's data-memory master port (`wb_cyc`/`wb_stb`/`wb_we`/`wb_addr`/`wb_wr_data`/`wb_sel`/`wb_ack`/`wb_stall`/`wb_rd_data`). It holds a word-addressed RAM with byte-lane writes and answers every accepted request in order with exactly one `wb_ack` or `wb_err`. A wait-state counter drives `wb_stall` so the core's load/store stage can be exercised against slow memory.

## Interface
- `DEPTH_WORDS`, default 1024: RAM size in 32-bit words; power of two, at least 2.
- `WAIT_STATES`, default 0: stall cycles inserted before each request is accepted; range 0..15.
- `clk` in 1: clock; all logic is rising-edge.
- `rst` in 1: reset; asynchronous, active-low.
- `wb_cyc` in 1: bus cycle active.
- `wb_stb` in 1: request strobe.
- `wb_we` in 1: 1 = write, 0 = read.
- `wb_addr` in 32: byte address; bits [1:0] are ignored.
- `wb_wr_data` in 32: write data.
- `wb_sel` in 4: byte-lane enables; bit i maps to bits [8i+7:8i].
- `wb_ack` out 1: normal termination, one per accepted in-range request.
- `wb_err` out 1: error termination, for an out-of-range word index.
- `wb_stall` out 1: request not accepted this cycle.
- `wb_rd_data` out 32: read data, valid only while `wb_ack` is high.

## Operation
- Request: `req = wb_cyc & wb_stb`. Accept: `req & ~wb_stall`.
- Word index: `idx = wb_addr[31:2]`. In range means `idx < DEPTH_WORDS`.
- Wait-state FSM has two states, IDLE and WAIT, with a 4-bit counter `cnt`.
  - IDLE with `WAIT_STATES == 0`: `wb_stall = 0`, so any request is accepted immediately.
  - IDLE with `req` and `WAIT_STATES > 0`: `wb_stall = 1`, load `cnt = WAIT_STATES - 1`, go to WAIT.
  - WAIT: `wb_stall = (cnt != 0)`. If `cnt != 0`, decrement it. When `cnt == 0` the request is accepted and the FSM returns to IDLE.
  - WAIT with `wb_cyc = 0`: return to IDLE. No termination is produced and no write occurs.
  - `wb_stall` is a combinational function of the state, `cnt` and `req`. It is 0 whenever `req = 0` in IDLE.
- Accepted write, in range: on the accept edge, write the bytes whose `wb_sel` bit is 1; other bytes are unchanged. `wb_sel = 0` writes nothing but is still acked.
- Accepted read, in range: on the accept edge, capture `mem[idx]` into the `wb_rd_data` register. `wb_sel` is ignored for reads; the full word is returned.
- Read-after-write to the same word in back-to-back cycles returns the new data, because the write commits before the next accept edge.
- Out of range: no write. On the next cycle `wb_err = 1`, `wb_ack = 0`, `wb_rd_data = 0`.
- On a write ack, `wb_rd_data = 0`.
- RAM contents are not affected by reset.

## Timing
- Outputs after reset: `wb_ack = 0`, `wb_err = 0`, `wb_rd_data = 0`; FSM in IDLE, `cnt = 0`. With `req = 0`, `wb_stall = 0`.
- Latency: a request accepted at edge N is terminated (`wb_ack` or `wb_err`) during cycle N+1, high for exactly one cycle.
- `WAIT_STATES = W > 0`: a request first presented in cycle N sees `wb_stall` high in cycles N..N+W-1 and is accepted at the end of cycle N+W. Every request pays the full W cycles, including back-to-back ones.
- `WAIT_STATES = 0`: one accept per cycle. Back-to-back requests get back-to-back acks.
- Termination is gated by cycle: if `wb_cyc = 0` in cycle N+1, `wb_ack` and `wb_err` stay 0. A write accepted at N remains committed.
- Reset asserted mid-operation: pending termination and FSM state clear immediately (asynchronously). A write already past its accept edge remains committed.
- Terminations are never generated without a prior accept. At most one termination is outstanding.

## Test plan
- Reset, `WAIT_STATES = 0`: write `0xDEADBEEF` to address `0x10` with `sel = 0xF`, then read `0x10` in the next cycle. Required: `wb_stall` stays 0, `ack` one cycle after each accept, read returns `0xDEADBEEF`.
- Byte lanes: word `0x10` holds `0xDEADBEEF`; write `0x11223344` with `sel = 0b0101`. A following read returns `0xDE22BE44`.
- `WAIT_STATES = 3`: hold a read of `0x10`. Required: `wb_stall` high exactly 3 cycles, accept on the 4th cycle, `ack` on the 5th with correct data. A second back-to-back read also stalls 3 cycles.
- Out of range, `DEPTH_WORDS = 1024`: write to `0x1000` (word 1024). Required: `wb_err = 1` for one cycle, `ack = 0`; a read of word 0 is unchanged.
- Abort: with `WAIT_STATES = 2`, drop `wb_cyc` during the stall. Required: no `ack`/`err` and memory unchanged. Then drop `cyc` in the ack cycle of a write of `0xCAFEF00D`: no `ack`, but a later read returns `0xCAFEF00D`.
- Pull `rst` low in the cycle between accept and ack. Required: `ack`, `err` and `rd_data` go to 0 immediately, `stall` is 0, and normal operation resumes after `rst` goes high.

Source files
------------

// File: rtl/wb_data_mem.sv
// Wishbone B4 pipelined slave data memory: word RAM with byte-lane writes,
// in-order single-cycle termination and a programmable wait-state stall.
module wb_data_mem #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [31:0] wb_addr,
  input  logic [31:0] wb_wr_data,
  input  logic [3:0]  wb_sel,
  output logic        wb_ack,
  output logic        wb_err,
  output logic        wb_stall,
  output logic [31:0] wb_rd_data
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = 4;
  localparam int unsigned DW = 32;
  localparam logic [CW-1:0] CNT_LOAD = CW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t          state_q, state_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic            ack_q, err_q;
  logic [DW-1:0]   rd_q;
  logic            req_c, accept_c, stall_c, in_range_c;
  logic [AW-1:0]   idx_c;
  logic            unused_addr;

  logic [DW-1:0] mem [DEPTH_WORDS];

  assign req_c       = wb_cyc & wb_stb;
  assign in_range_c  = wb_addr[31:2] < 30'(DEPTH_WORDS);
  assign idx_c       = wb_addr[AW+1:2];
  assign unused_addr = ^wb_addr[1:0];

  // Wait-state sequencing: every request pays the full stall count before accept
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    stall_c  = 1'b0;
    accept_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_c) begin
          if (WAIT_STATES == 0) begin
            accept_c = 1'b1;
          end else begin
            stall_c = 1'b1;
            cnt_n   = CNT_LOAD;
            state_n = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        stall_c = (cnt_q != '0);
        if (!wb_cyc) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (cnt_q != '0) begin
          cnt_n = cnt_q - CW'(1);
        end else if (req_c) begin
          accept_c = 1'b1;
          state_n  = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      ack_q   <= accept_c & in_range_c;
      err_q   <= accept_c & ~in_range_c;
      rd_q    <= (accept_c && !wb_we && in_range_c) ? mem[idx_c] : '0;
    end
  end

  // RAM is deliberately not reset; only selected byte lanes are written
  always_ff @(posedge clk) begin
    if (accept_c && wb_we && in_range_c) begin
      for (int i = 0; i < 4; i++) begin
        if (wb_sel[i]) mem[idx_c][8*i +: 8] <= wb_wr_data[8*i +: 8];
      end
    end
  end

  // A termination is only visible while the master still holds the cycle
  assign wb_ack     = ack_q & wb_cyc;
  assign wb_err     = err_q & wb_cyc;
  assign wb_stall   = stall_c;
  assign wb_rd_data = rd_q;

endmodule

// File: tb/tb_wb_data_mem.sv
// Bench for wb_data_mem: three instances (0, 3 and 2 wait states) driven by
// directed and random bursts, checked against a word/byte-level memory model.
module tb_wb_data_mem;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cyc [3] = '{default: 1'b0};
  logic        stb [3] = '{default: 1'b0};
  logic        we  [3] = '{default: 1'b0};
  logic [31:0] addr[3] = '{default: 32'h0};
  logic [31:0] wdat[3] = '{default: 32'h0};
  logic [3:0]  sel [3] = '{default: 4'h0};
  logic        ack [3];
  logic        err [3];
  logic        stall[3];
  logic [31:0] rdat[3];

  logic [31:0] ref_mem [3][1024];
  bit   [3:0]  known   [3][1024];
  txn_t        q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  wb_data_mem #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .wb_cyc(cyc[0]), .wb_stb(stb[0]), .wb_we(we[0]),
    .wb_addr(addr[0]), .wb_wr_data(wdat[0]), .wb_sel(sel[0]),
    .wb_ack(ack[0]), .wb_err(err[0]), .wb_stall(stall[0]), .wb_rd_data(rdat[0]));

  wb_data_mem #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .wb_cyc(cyc[1]), .wb_stb(stb[1]), .wb_we(we[1]),
    .wb_addr(addr[1]), .wb_wr_data(wdat[1]), .wb_sel(sel[1]),
    .wb_ack(ack[1]), .wb_err(err[1]), .wb_stall(stall[1]), .wb_rd_data(rdat[1]));

  wb_data_mem #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .rst(rst), .wb_cyc(cyc[2]), .wb_stb(stb[2]), .wb_we(we[2]),
    .wb_addr(addr[2]), .wb_wr_data(wdat[2]), .wb_sel(sel[2]),
    .wb_ack(ack[2]), .wb_err(err[2]), .wb_stall(stall[2]), .wb_rd_data(rdat[2]));

  function automatic int ws(input int d);
    case (d)
      0:       return 0;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic add(input bit w, input logic [31:0] a, input logic [31:0] dat, input logic [3:0] s);
    txn_t t;
    t.we = w; t.addr = a; t.data = dat; t.sel = s;
    q.push_back(t);
  endtask

  // Reference behaviour of one accepted request: returns the expected termination
  task automatic model_accept(input int d, input txn_t t, output bit a, output bit e,
                              output logic [31:0] rd, output bit chk);
    int unsigned idx;
    idx = 32'(t.addr[31:2]);
    chk = 1'b1;
    rd  = 32'h0;
    if (idx >= 1024) begin
      a = 1'b0; e = 1'b1;
    end else begin
      a = 1'b1; e = 1'b0;
      if (t.we) begin
        for (int b = 0; b < 4; b++) begin
          if (t.sel[b]) begin
            ref_mem[d][idx][8*b +: 8] = t.data[8*b +: 8];
            known[d][idx][b] = 1'b1;
          end
        end
      end else begin
        rd  = ref_mem[d][idx];
        chk = (known[d][idx] == 4'hF);
      end
    end
  endtask

  // Issue the queued requests back-to-back on instance d and check every cycle
  task automatic burst(input int d);
    txn_t        cur;
    bit          pend = 1'b0, p_ack = 1'b0, p_err = 1'b0, p_chk = 1'b0;
    logic [31:0] p_rd = 32'h0;
    int          stalls = 0;
    @(negedge clk);
    while (q.size() > 0 || pend) begin
      if (q.size() > 0) begin
        cur = q[0];
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = cur.we;
        addr[d] = cur.addr; wdat[d] = cur.data; sel[d] = cur.sel;
      end else begin
        stb[d] = 1'b0;
      end
      #1;
      if (pend) begin
        check("ack", 32'(ack[d]), 32'(p_ack));
        check("err", 32'(err[d]), 32'(p_err));
        if (p_chk) check("rd_data", rdat[d], p_rd);
        pend = 1'b0;
      end else begin
        check("no_ack", 32'(ack[d]), 32'h0);
        check("no_err", 32'(err[d]), 32'h0);
      end
      if (q.size() > 0) begin
        if (stall[d] === 1'b1 && stalls < 40) begin
          stalls++;
        end else begin
          check("stall_cycles", 32'(stalls), 32'(ws(d)));
          model_accept(d, cur, p_ack, p_err, p_rd, p_chk);
          pend = 1'b1;
          stalls = 0;
          q.delete(0);
        end
      end
      @(negedge clk);
    end
    #1;
    check("ack_one_cycle", 32'(ack[d]), 32'h0);
    check("err_one_cycle", 32'(err[d]), 32'h0);
    cyc[d] = 1'b0; stb[d] = 1'b0;
  endtask

  task automatic rand_txns(input int n);
    int unsigned w;
    for (int i = 0; i < n; i++) begin
      w = ($urandom_range(0, 9) == 0) ? 1024 + $urandom_range(0, 1000) : $urandom_range(0, 15);
      add(1'($urandom_range(0, 1)), (w << 2) | 32'($urandom_range(0, 3)), $urandom,
          ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom));
    end
  endtask

  task automatic abort_in_stall();
    @(negedge clk);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1;
    addr[2] = 32'h20; wdat[2] = 32'h12345678; sel[2] = 4'hF;
    #1 check("abort_stall0", 32'(stall[2]), 32'h1);
    @(negedge clk);
    #1 check("abort_stall1", 32'(stall[2]), 32'h1);
    cyc[2] = 1'b0; stb[2] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("abort_no_ack", 32'(ack[2]), 32'h0);
      check("abort_no_err", 32'(err[2]), 32'h0);
    end
  endtask

  task automatic drop_in_ack_cycle();
    txn_t        t;
    bit          a, e, c;
    logic [31:0] r;
    int          k = 0;
    @(negedge clk);
    t.we = 1'b1; t.addr = 32'h20; t.data = 32'hCAFEF00D; t.sel = 4'hF;
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = t.we;
    addr[2] = t.addr; wdat[2] = t.data; sel[2] = t.sel;
    #1;
    while (stall[2] === 1'b1 && k < 40) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("drop_stalls", 32'(k), 32'h2);
    model_accept(2, t, a, e, r, c);
    @(negedge clk);
    cyc[2] = 1'b0; stb[2] = 1'b0;
    #1;
    check("drop_no_ack", 32'(ack[2]), 32'h0);
    check("drop_no_err", 32'(err[2]), 32'h0);
  endtask

  task automatic reset_mid_op();
    @(negedge clk);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10; sel[0] = 4'hF;
    @(posedge clk);
    #1 check("pre_rst_ack", 32'(ack[0]), 32'h1);
    rst = 1'b0;
    #1;
    check("rst_ack", 32'(ack[0]), 32'h0);
    check("rst_err", 32'(err[0]), 32'h0);
    check("rst_rd_data", rdat[0], 32'h0);
    check("rst_stall", 32'(stall[0]), 32'h0);
    stb[0] = 1'b0; cyc[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("reset_ack", 32'(ack[d]), 32'h0);
      check("reset_err", 32'(err[d]), 32'h0);
      check("reset_rd_data", rdat[d], 32'h0);
      check("reset_stall", 32'(stall[d]), 32'h0);
    end
    rst = 1'b1;

    // Zero wait states: write then read-after-write, byte lanes, out-of-range
    add(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    add(1'b0, 32'h10, 32'h0, 4'h0);
    burst(0);
    add(1'b1, 32'h10, 32'h11223344, 4'b0101);
    add(1'b0, 32'h10, 32'h0, 4'h0);
    add(1'b1, 32'h14, 32'h55667788, 4'h0);
    burst(0);
    add(1'b1, 32'h0, 32'h0F0F0F0F, 4'hF);
    add(1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF);
    add(1'b0, 32'h0, 32'h0, 4'h0);
    add(1'b0, 32'h1000, 32'h0, 4'h0);
    burst(0);

    // Three wait states, back-to-back reads
    add(1'b1, 32'h10, 32'hA5A5C3C3, 4'hF);
    add(1'b0, 32'h10, 32'h0, 4'h0);
    add(1'b0, 32'h10, 32'h0, 4'h0);
    burst(1);

    // Two wait states: aborts during stall and during the ack cycle
    add(1'b1, 32'h20, 32'h0BADF00D, 4'hF);
    burst(2);
    abort_in_stall();
    add(1'b0, 32'h20, 32'h0, 4'h0);
    burst(2);
    drop_in_ack_cycle();
    add(1'b0, 32'h20, 32'h0, 4'h0);
    burst(2);

    reset_mid_op();
    add(1'b0, 32'h10, 32'h0, 4'h0);
    burst(0);

    for (int d = 0; d < 3; d++) begin
      rand_txns(40);
      burst(d);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
